// File: rtl/hamming_protected_counter.sv
// 16-bit up-counter whose state is held as a SECDED Hamming codeword.
// The stored word is decoded, corrected and re-encoded on every clock.
module hamming_protected_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] counter,
  output logic        err_corrected,
  output logic        err_uncorrectable
);

  localparam int DPOS [16] = '{
    3, 5, 6, 7, 9, 10, 11, 12,
    13, 14, 15, 17, 18, 19, 20, 21
  };

  logic [15:0] count_q;
  logic [5:0]  parity_q;
  logic [15:0] count_reg;
  logic [5:0]  parity_stored;
  logic [4:0]  syn;
  logic        ovr;
  logic [15:0] fixed;
  logic [15:0] nxt;
  logic        corr;
  logic        unc;

  // Check bit k is bit k of the XOR of positions of set data bits.
  function automatic logic [5:0] encode(input logic [15:0] d);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (d[i]) p ^= 5'(DPOS[i]);
    return {p, ^d ^ ^p};
  endfunction

  // Stored word observed through nets so upsets can be injected.
  assign count_reg     = count_q;
  assign parity_stored = parity_q;

  always_comb begin
    syn = parity_stored[5:1];
    for (int i = 0; i < 16; i++)
      if (count_reg[i]) syn ^= 5'(DPOS[i]);
    ovr   = ^{count_reg, parity_stored};
    fixed = count_reg;
    corr  = 1'b0;
    unc   = 1'b0;
    unique case (1'b1)
      (!ovr && syn == 5'd0): ;
      (ovr && syn <= 5'd21): begin
        corr = 1'b1;
        for (int i = 0; i < 16; i++)
          if (DPOS[i] == int'(syn)) fixed[i] = ~count_reg[i];
      end
      default: unc = 1'b1;
    endcase
  end

  always_comb begin
    if (unc) nxt = count_reg;
    else     nxt = fixed + {15'b0, enable};
  end

  assign counter           = fixed;
  assign err_corrected     = corr;
  assign err_uncorrectable = unc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      parity_q <= '0;
    end else begin
      count_q  <= nxt;
      parity_q <= encode(nxt);
    end
  end

endmodule

// File: tb/tb_hamming_protected_counter.sv
// Bench for the SECDED-protected counter: a codeword-array reference
// model drives expectations for counting, upsets and reset.
module tb_hamming_protected_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] counter;
  logic        err_corrected;
  logic        err_uncorrectable;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic [15:0] inj_d;
  logic [5:0]  inj_p;

  hamming_protected_counter dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .counter(counter),
    .err_corrected(err_corrected),
    .err_uncorrectable(err_uncorrectable)
  );

  always #5 clk = ~clk;

  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic logic [5:0] m_encode(input logic [15:0] d);
    logic cw [22];
    logic [5:0] r;
    int j;
    logic b;
    for (int i = 0; i < 22; i++) cw[i] = 1'b0;
    j = 0;
    for (int pos = 1; pos <= 21; pos++)
      if (!is_pow2(pos)) begin
        cw[pos] = d[j];
        j++;
      end
    r = '0;
    for (int k = 0; k < 5; k++) begin
      b = 1'b0;
      for (int pos = 1; pos <= 21; pos++)
        if (!is_pow2(pos) && ((pos >> k) & 1) == 1 && cw[pos]) b = ~b;
      r[k+1] = b;
      cw[1 << k] = b;
    end
    b = 1'b0;
    for (int pos = 1; pos <= 21; pos++) b ^= cw[pos];
    r[0] = b;
    return r;
  endfunction

  task automatic m_decode(input logic [15:0] d, input logic [5:0] p,
                          output logic [15:0] val,
                          output logic c, output logic u);
    logic cw [22];
    int syn;
    int j;
    bit o;
    cw[0] = p[0];
    for (int k = 0; k < 5; k++) cw[1 << k] = p[k+1];
    j = 0;
    for (int pos = 1; pos <= 21; pos++)
      if (!is_pow2(pos)) begin
        cw[pos] = d[j];
        j++;
      end
    syn = 0;
    o = 0;
    for (int pos = 0; pos <= 21; pos++)
      if (cw[pos]) begin
        syn = syn ^ pos;
        o = ~o;
      end
    val = d;
    c = 1'b0;
    u = 1'b0;
    if (syn == 0 && !o) begin
    end else if (o && syn <= 21) begin
      c = 1'b1;
      if (syn != 0) cw[syn] = ~cw[syn];
      j = 0;
      for (int pos = 1; pos <= 21; pos++)
        if (!is_pow2(pos)) begin
          val[j] = cw[pos];
          j++;
        end
    end else begin
      u = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Overlay an upset on the clean stored word of exp_cnt and follow it
  // through one clock edge; mask [21:6] hits data, [5:0] hits parity.
  task automatic inject(input logic [21:0] mask, input string name);
    logic [15:0] v;
    logic        c;
    logic        u;
    logic [15:0] nxt;
    inj_d = exp_cnt ^ mask[21:6];
    inj_p = m_encode(exp_cnt) ^ mask[5:0];
    force dut.count_reg = inj_d;
    force dut.parity_stored = inj_p;
    #1;
    m_decode(inj_d, inj_p, v, c, u);
    checks++;
    if ({counter, err_corrected, err_uncorrectable} !== {v, c, u}) begin
      errors++;
      $display("FAIL %s_upset got %h/%b/%b exp %h/%b/%b",
               name, counter, err_corrected, err_uncorrectable, v, c, u);
    end
    nxt = u ? inj_d : v + (enable ? 16'd1 : 16'd0);
    @(posedge clk);
    #1;
    release dut.count_reg;
    release dut.parity_stored;
    exp_cnt = nxt;
    @(negedge clk);
    checks++;
    if ({counter, err_corrected, err_uncorrectable} !== {exp_cnt, 2'b00}) begin
      errors++;
      $display("FAIL %s_scrub got %h/%b/%b exp %h/0/0",
               name, counter, err_corrected, err_uncorrectable, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    checks++;
    if ({counter, err_corrected, err_uncorrectable} !== 18'h0) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%b exp 0000/0/0",
               counter, err_corrected, err_uncorrectable);
    end
    reset = 1'b1;
    exp_cnt = 16'h0;
  endtask

  task automatic test_count();
    enable = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if ({counter, err_corrected, err_uncorrectable} !==
          {16'(i), 2'b00}) begin
        errors++;
        $display("FAIL count_%0d got %h/%b/%b exp %h/0/0",
                 i, counter, err_corrected, err_uncorrectable, 16'(i));
      end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    repeat (5) tick();
    checks++;
    if (counter !== 16'd45) begin
      errors++;
      $display("FAIL hold got %h exp 002d", counter);
    end
    enable = 1'b1;
    repeat (5) tick();
    exp_cnt = 16'd50;
    checks++;
    if (counter !== 16'd50) begin
      errors++;
      $display("FAIL resume got %h exp 0032", counter);
    end
  endtask

  task automatic test_single_data();
    enable = 1'b0;
    tick();
    checks++;
    if (counter !== 16'd50) begin
      errors++;
      $display("FAIL single_pre got %h exp 0032", counter);
    end
    inject(22'(1) << (6 + 3), "single_d3_hold");
    enable = 1'b1;
    inject(22'(1) << (6 + 3), "single_d3_count");
    checks++;
    if (counter !== 16'd51) begin
      errors++;
      $display("FAIL single_value got %h exp 0033", counter);
    end
  endtask

  task automatic test_parity_p0();
    enable = 1'b0;
    inject(22'h1, "p0_only");
    inject(22'h20, "p16_only");
  endtask

  task automatic test_double();
    enable = 1'b1;
    inject((22'(1) << 6) | (22'(1) << 7), "double_d0d1");
    enable = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({counter, err_corrected, err_uncorrectable} !== {exp_cnt, 2'b00}) begin
      errors++;
      $display("FAIL double_resume got %h exp %h", counter, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    enable = 1'b0;
    exp_cnt = 16'hFFFE;
    inject(22'h0, "preload");
    enable = 1'b1;
    tick();
    checks++;
    if (counter !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_ffff got %h exp ffff", counter);
    end
    tick();
    exp_cnt = 16'h0000;
    checks++;
    if ({counter, err_corrected, err_uncorrectable} !== 18'h0) begin
      errors++;
      $display("FAIL wrap_zero got %h/%b/%b exp 0000/0/0",
               counter, err_corrected, err_uncorrectable);
    end
  endtask

  task automatic test_random();
    int kind;
    int a;
    int b;
    logic [21:0] mask;
    for (int n = 0; n < 150; n++) begin
      enable = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      mask = '0;
      a = $urandom_range(0, 21);
      b = (a + $urandom_range(1, 21)) % 22;
      if (kind >= 4) mask[a] = 1'b1;
      if (kind >= 8) mask[b] = 1'b1;
      inject(mask, "random");
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({counter, err_corrected, err_uncorrectable} !== 18'h0) begin
      errors++;
      $display("FAIL async_reset got %h/%b/%b exp 0000/0/0",
               counter, err_corrected, err_uncorrectable);
    end
    @(negedge clk);
    tick();
    checks++;
    if (counter !== 16'h0) begin
      errors++;
      $display("FAIL reset_dominates got %h exp 0000", counter);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (counter !== 16'h1) begin
      errors++;
      $display("FAIL post_reset got %h exp 0001", counter);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_hold();
    test_single_data();
    test_parity_p0();
    test_double();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
